// File: rtl/fft_frame_ctrl.sv
// Frame controller wrapping a free-running FFT core: streams num_frames frames of
// N samples into the core and re-times its results into a framed, indexed output.
module fft_frame_ctrl #(
  parameter int DW      = 16,
  parameter int N       = 128,
  parameter int LATENCY = 140,
  localparam int IW     = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    num_frames,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_r,
  input  logic [DW-1:0] s_i,
  output logic [DW-1:0] fft_in_r,
  output logic [DW-1:0] fft_in_i,
  input  logic [DW-1:0] fft_out_r,
  input  logic [DW-1:0] fft_out_i,
  output logic          m_valid,
  output logic [DW-1:0] m_r,
  output logic [DW-1:0] m_i,
  output logic [IW-1:0] m_index,
  output logic          m_last,
  output logic          busy,
  output logic          done,
  output logic          underrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       nf_q, nf_d;
  logic [IW-1:0]    smp_cnt_q, smp_cnt_d;
  logic [7:0]       frm_cnt_q, frm_cnt_d;
  logic [IW-1:0]    out_cnt_q, out_cnt_d;
  logic [7:0]       out_frm_q, out_frm_d;
  logic [LATENCY:0] vsr_q, vsr_d;
  logic [DW-1:0]    fft_in_r_q, fft_in_r_d, fft_in_i_q, fft_in_i_d;
  logic             m_valid_q, m_valid_d;
  logic [DW-1:0]    m_r_q, m_r_d, m_i_q, m_i_d;
  logic [IW-1:0]    m_index_q, m_index_d;
  logic             m_last_q, m_last_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;

  always_comb begin
    state_d    = state_q;
    nf_d       = nf_q;
    smp_cnt_d  = smp_cnt_q;
    frm_cnt_d  = frm_cnt_q;
    out_cnt_d  = out_cnt_q;
    out_frm_d  = out_frm_q;
    vsr_d      = {vsr_q[LATENCY-1:0], 1'b0};
    fft_in_r_d = '0;
    fft_in_i_d = '0;
    m_valid_d  = vsr_q[LATENCY];
    m_r_d      = m_r_q;
    m_i_d      = m_i_q;
    m_index_d  = m_index_q;
    m_last_d   = 1'b0;
    done_d     = 1'b0;
    underrun_d = underrun_q;

    // Tail of the slot shift register marks the cycle the core result for a slot is valid.
    if (vsr_q[LATENCY]) begin
      m_r_d     = fft_out_r;
      m_i_d     = fft_out_i;
      m_index_d = out_cnt_q;
      out_cnt_d = out_cnt_q + IW'(1);
      if (out_cnt_q == IW'(N - 1)) begin
        m_last_d  = 1'b1;
        out_frm_d = out_frm_q + 8'd1;
        done_d    = (out_frm_q == nf_q - 8'd1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start && num_frames != 8'd0) begin
          state_d    = ST_LOAD;
          nf_d       = num_frames;
          underrun_d = 1'b0;
          smp_cnt_d  = '0;
          frm_cnt_d  = '0;
          out_cnt_d  = '0;
          out_frm_d  = '0;
        end
      end
      ST_LOAD: begin
        // The core never stalls, so a missing sample still occupies its slot as zeros.
        vsr_d[0] = 1'b1;
        if (s_valid) begin
          fft_in_r_d = s_r;
          fft_in_i_d = s_i;
        end else begin
          underrun_d = 1'b1;
        end
        smp_cnt_d = smp_cnt_q + IW'(1);
        if (smp_cnt_q == IW'(N - 1)) begin
          smp_cnt_d = '0;
          frm_cnt_d = frm_cnt_q + 8'd1;
          if (frm_cnt_q == nf_q - 8'd1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (done_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      nf_q       <= '0;
      smp_cnt_q  <= '0;
      frm_cnt_q  <= '0;
      out_cnt_q  <= '0;
      out_frm_q  <= '0;
      vsr_q      <= '0;
      fft_in_r_q <= '0;
      fft_in_i_q <= '0;
      m_valid_q  <= 1'b0;
      m_r_q      <= '0;
      m_i_q      <= '0;
      m_index_q  <= '0;
      m_last_q   <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nf_q       <= nf_d;
      smp_cnt_q  <= smp_cnt_d;
      frm_cnt_q  <= frm_cnt_d;
      out_cnt_q  <= out_cnt_d;
      out_frm_q  <= out_frm_d;
      vsr_q      <= vsr_d;
      fft_in_r_q <= fft_in_r_d;
      fft_in_i_q <= fft_in_i_d;
      m_valid_q  <= m_valid_d;
      m_r_q      <= m_r_d;
      m_i_q      <= m_i_d;
      m_index_q  <= m_index_d;
      m_last_q   <= m_last_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign s_ready  = (state_q == ST_LOAD);
  assign busy     = (state_q != ST_IDLE);
  assign fft_in_r = fft_in_r_q;
  assign fft_in_i = fft_in_i_q;
  assign m_valid  = m_valid_q;
  assign m_r      = m_r_q;
  assign m_i      = m_i_q;
  assign m_index  = m_index_q;
  assign m_last   = m_last_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: a delay-line FFT core stand-in, a run-level reference
// model with an expected-output queue, and a table of run scenarios.
module tb_fft_frame_ctrl;
  localparam int DW  = 16;
  localparam int N   = 128;
  localparam int LAT = 140;
  localparam int IW  = $clog2(N);
  localparam logic [DW-1:0] CORE_X = 16'h3C3C;

  logic          clk = 1'b0;
  logic          rst, start, s_valid, s_ready;
  logic [7:0]    num_frames;
  logic [DW-1:0] s_r, s_i, fft_in_r, fft_in_i, fft_out_r, fft_out_i, m_r, m_i;
  logic          m_valid, m_last, busy, done, underrun;
  logic [IW-1:0] m_index;

  always #5 clk = ~clk;

  fft_frame_ctrl #(.DW(DW), .N(N), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .num_frames(num_frames),
    .s_valid(s_valid), .s_ready(s_ready), .s_r(s_r), .s_i(s_i),
    .fft_in_r(fft_in_r), .fft_in_i(fft_in_i),
    .fft_out_r(fft_out_r), .fft_out_i(fft_out_i),
    .m_valid(m_valid), .m_r(m_r), .m_i(m_i), .m_index(m_index), .m_last(m_last),
    .busy(busy), .done(done), .underrun(underrun)
  );

  // Core stand-in: fixed LAT-cycle delay, real part XORed so pass-through is distinguishable.
  logic [DW-1:0] pr [LAT];
  logic [DW-1:0] pi [LAT];
  initial for (int j = 0; j < LAT; j++) begin pr[j] = '0; pi[j] = '0; end
  always @(posedge clk) begin
    pr[0] <= fft_in_r ^ CORE_X;
    pi[0] <= fft_in_i;
    for (int j = 1; j < LAT; j++) begin pr[j] <= pr[j-1]; pi[j] <= pi[j-1]; end
  end
  assign fft_out_r = pr[LAT-1];
  assign fft_out_i = pi[LAT-1];

  typedef struct {
    int            due;
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    int            idx;
    bit            last;
    bit            dn;
  } exp_t;
  exp_t q[$];

  int cyc = 0, checks = 0, failures = 0, obs_valid = 0, obs_done = 0;
  bit m_busy = 0, m_clr = 0, m_und = 0;
  int m_left = 0, m_slot = 0, m_nf = 0;
  logic [DW-1:0] m_fr = '0, m_fi = '0, m_hr = '0, m_hi = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    bit   ob;
    exp_t e;
    @(posedge clk);
    cyc++;
    ob   = m_busy;
    m_fr = '0;
    m_fi = '0;
    if (rst) begin
      m_busy = 0; m_clr = 0; m_left = 0; m_und = 0; m_hr = '0; m_hi = '0;
      q.delete();
    end else begin
      if (m_clr) begin m_busy = 0; m_clr = 0; end
      if (m_left > 0) begin
        if (s_valid) begin m_fr = s_r; m_fi = s_i; end
        else m_und = 1;
        e.due  = cyc + LAT + 1;
        e.r    = m_fr ^ CORE_X;
        e.i    = m_fi;
        e.idx  = m_slot % N;
        e.last = (e.idx == N - 1);
        e.dn   = (m_slot == m_nf * N - 1);
        q.push_back(e);
        m_slot++;
        m_left--;
      end else if (!ob && start && num_frames != 8'd0) begin
        m_busy = 1; m_nf = num_frames; m_left = m_nf * N; m_slot = 0; m_und = 0;
      end
    end
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check("m_valid", 32'(m_valid), 32'd1);
      check("m_r", 32'(m_r), 32'(e.r));
      check("m_i", 32'(m_i), 32'(e.i));
      check("m_index", 32'(m_index), 32'(e.idx));
      check("m_last", 32'(m_last), 32'(e.last));
      check("done", 32'(done), 32'(e.dn));
      m_hr = e.r;
      m_hi = e.i;
      if (e.dn) m_clr = 1;
    end else begin
      check("m_valid_idle", 32'(m_valid), 32'd0);
      check("m_last_idle", 32'(m_last), 32'd0);
      check("done_idle", 32'(done), 32'd0);
      check("m_r_hold", 32'(m_r), 32'(m_hr));
      check("m_i_hold", 32'(m_i), 32'(m_hi));
    end
    check("busy", 32'(busy), 32'(m_busy));
    check("s_ready", 32'(s_ready), 32'(m_left > 0));
    check("underrun", 32'(underrun), 32'(m_und));
    check("fft_in_r", 32'(fft_in_r), 32'(m_fr));
    check("fft_in_i", 32'(fft_in_i), 32'(m_fi));
    if (m_valid) obs_valid++;
    if (done) obs_done++;
  endtask

  typedef struct {
    int nf;
    int gap;
    int rst_at;
    int ill_at;
    bit rst_start;
    bit ramp;
    bit rnd_gap;
    int min_cyc;
    int exp_out;
    int exp_done;
    bit exp_und;
  } scen_t;

  scen_t tbl[9];

  initial begin
    scen_t sc;
    int    n;
    bit    fin;
    //          nf gap  rst  ill  rs ramp rg  min  out  dn und
    tbl[0] = '{1, -1,  -1,  -1,  0, 1,   0,  0,   128, 1, 0};  // ramp
    tbl[1] = '{3, -1,  -1,  -1,  0, 0,   0,  0,   384, 1, 0};  // back to back
    tbl[2] = '{1, 50,  -1,  -1,  0, 0,   0,  0,   128, 1, 1};  // gap
    tbl[3] = '{0, -1,  -1,  -1,  0, 0,   0,  5,   0,   0, 1};  // nf=0 ignored
    tbl[4] = '{2, -1,  -1,  10,  0, 0,   0,  0,   256, 1, 0};  // start in LOAD
    tbl[5] = '{2, -1,  200, -1,  0, 0,   0,  520, 59,  0, 0};  // reset mid-run
    tbl[6] = '{1, -1,  -1,  -1,  0, 1,   0,  0,   128, 1, 0};  // fresh run
    tbl[7] = '{1, -1,  -1,  -1,  1, 0,   0,  5,   0,   0, 0};  // rst with start
    tbl[8] = '{2, 3,   -1,  -1,  0, 0,   1,  0,   256, 1, 1};  // random gaps

    rst = 1; start = 0; num_frames = '0; s_valid = 0; s_r = '0; s_i = '0;
    step();
    step();
    rst = 0;

    for (int s = 0; s < 9; s++) begin
      sc = tbl[s];
      obs_valid = 0;
      obs_done  = 0;
      s_valid = 1;
      repeat (3) begin
        s_r = DW'($urandom);
        s_i = DW'($urandom);
        step();
      end
      start = 1; num_frames = 8'(sc.nf); rst = sc.rst_start;
      step();
      start = 0; rst = 0;
      n = 0;
      fin = 0;
      while (!fin) begin
        s_r = DW'($urandom);
        s_i = DW'($urandom);
        s_valid = 1;
        if (m_left > 0) begin
          if (sc.ramp) begin s_r = DW'(m_slot * 256); s_i = DW'(m_slot * 256); end
          if (m_slot == sc.gap || (sc.rnd_gap && $urandom_range(0, 7) == 0)) s_valid = 0;
          if (m_slot == sc.rst_at) rst = 1;
          if (m_slot == sc.ill_at) begin start = 1; num_frames = 8'd5; end
        end
        step();
        rst = 0;
        start = 0;
        n++;
        if (n >= sc.min_cyc && !m_busy && q.size() == 0) fin = 1;
        if (n > 3000) begin
          check("run_timeout", 32'(n), 32'd3000);
          fin = 1;
        end
      end
      check($sformatf("scen%0d_outputs", s), 32'(obs_valid), 32'(sc.exp_out));
      check($sformatf("scen%0d_dones", s), 32'(obs_done), 32'(sc.exp_done));
      check($sformatf("scen%0d_underrun", s), 32'(underrun), 32'(sc.exp_und));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
